// File: rtl/super_fec_i3_enc.sv
// -----------------------------------------------------------------------------
// super_fec_i3_enc
//   Systematic encoder for the super-FEC frame. A frame is 255 words of
//   128 bits. Words 0..238 are data and are echoed to the output. Words
//   239..254 are parity: 16 interleaved lanes, each a degree-128 polynomial
//   LFSR that absorbs 8 bits per data word and is then shifted out 8 bits per
//   parity word.
//
//   Lane l owns word bits l+16*b (b=0..7); b=0 is fed first, which places it
//   at the highest degree of the lane message.
//
// Ports
//   iclk     in   1    clock, rising edge
//   ireset   in   1    asynchronous active-low reset
//   iclkena  in   1    clock enable; every register holds while low
//   ival     in   1    input word valid
//   isop     in   1    start of frame (qualified by ival); aborts any frame
//   idat     in   128  input word (ignored during parity words)
//   oval     out  1    output word valid (1 cycle after ival)
//   osop     out  1    marks output word 0 of a frame
//   odat     out  128  data copy or parity word
// -----------------------------------------------------------------------------
module super_fec_i3_enc #(
  parameter logic [127:0] pPOLY       = 128'h87,
  parameter int           pDATA_WORDS = 239,
  parameter int           pCODE_WORDS = 255
) (
  input  logic         iclk,
  input  logic         ireset,
  input  logic         iclkena,
  input  logic         ival,
  input  logic         isop,
  input  logic [127:0] idat,
  output logic         oval,
  output logic         osop,
  output logic [127:0] odat
);

  localparam int         LANES    = 16;
  localparam int         BITS     = 8;
  localparam int         W        = 128;
  localparam logic [7:0] LAST_IDX = 8'(pCODE_WORDS - 1);
  localparam logic [7:0] DATA_END = 8'(pDATA_WORDS);

  // cnt_q is the index the next valid word takes unless it carries isop.
  logic [7:0]              cnt_q, cnt_d;
  logic [LANES-1:0][W-1:0] lane_q, lane_d;
  logic                    oval_q, oval_d;
  logic                    osop_q, osop_d;
  logic [W-1:0]            odat_q, odat_d;

  logic [7:0]              widx;
  logic [W-1:0]            r;
  logic                    fb;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    cnt_d  = cnt_q;
    lane_d = lane_q;
    odat_d = odat_q;
    oval_d = 1'b0;
    osop_d = 1'b0;
    widx   = isop ? 8'd0 : cnt_q;
    r      = '0;
    fb     = 1'b0;

    if (ival) begin
      cnt_d  = (widx == LAST_IDX) ? 8'd0 : widx + 8'd1;
      oval_d = 1'b1;
      osop_d = (widx == 8'd0);

      if (widx < DATA_END) begin
        odat_d = idat;
        for (int l = 0; l < LANES; l++) begin
          // Word 0 (explicit isop or wrap) starts every lane from a clean register.
          r = (widx == 8'd0) ? '0 : lane_q[l];
          // NOTE: r is a blocking temporary so the 8 serial LFSR steps chain within one cycle.
          for (int b = 0; b < BITS; b++) begin
            fb = r[W-1] ^ idat[l + LANES*b];
            r  = {r[W-2:0], 1'b0} ^ (fb ? pPOLY : '0);
          end
          lane_d[l] = r;
        end
      end else begin
        // Parity: top byte of each lane goes out interleaved, lane shifts up 8.
        for (int l = 0; l < LANES; l++) begin
          for (int b = 0; b < BITS; b++) begin
            odat_d[l + LANES*b] = lane_q[l][W-1-b];
          end
          lane_d[l] = {lane_q[l][W-1-BITS:0], {BITS{1'b0}}};
        end
      end
    end
  end

  // NOTE: state uses non-blocking assignments, and the lane array is reset like any
  // other flop because a mid-frame reset must leave no stale parity behind.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      cnt_q  <= '0;
      lane_q <= '0;
      oval_q <= 1'b0;
      osop_q <= 1'b0;
      odat_q <= '0;
    end else if (iclkena) begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
      oval_q <= oval_d;
      osop_q <= osop_d;
      odat_q <= odat_d;
    end
  end

  assign oval = oval_q;
  assign osop = osop_q;
  assign odat = odat_q;

endmodule

// File: tb/tb_super_fec_i3_enc.sv
// -----------------------------------------------------------------------------
// tb_super_fec_i3_enc
//   Self-checking bench for super_fec_i3_enc. Expected parity comes from a
//   polynomial long division of each lane message (m(x)*x^128 mod g(x)).
// -----------------------------------------------------------------------------
module tb_super_fec_i3_enc;

  localparam int           ND   = 239;
  localparam int           NC   = 255;
  localparam logic [127:0] POLY = 128'h87;

  logic         iclk = 1'b0;
  logic         ireset, iclkena, ival, isop;
  logic [127:0] idat;
  logic         oval, osop;
  logic [127:0] odat;

  super_fec_i3_enc dut (
    .iclk    (iclk),
    .ireset  (ireset),
    .iclkena (iclkena),
    .ival    (ival),
    .isop    (isop),
    .idat    (idat),
    .oval    (oval),
    .osop    (osop),
    .odat    (odat)
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;

  logic [127:0] stim [NC];
  logic [127:0] expw [NC];
  logic [127:0] fr_a [NC];
  logic [127:0] fr_b [NC];
  logic [127:0] par_a[16];
  logic [127:0] par_b[16];

  // Output capture: one entry per enabled edge that produced a valid word.
  logic [127:0] cap_dat[$];
  bit           cap_sop[$];
  bit           en_s = 1'b0;

  always @(posedge iclk) en_s = iclkena;
  always @(negedge iclk) begin
    if (en_s && oval === 1'b1) begin
      cap_dat.push_back(odat);
      cap_sop.push_back(osop);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: per lane, build m(x)*x^128 with feed-order bit j at degree
  // 1911-j+128, divide by g(x) and lay the remainder out into 16 words.
  task automatic model();
    logic [2047:0] dv;
    logic [2047:0] g;
    logic [127:0]  rem[16];
    g = 2048'({1'b1, POLY});
    for (int l = 0; l < 16; l++) begin
      dv = '0;
      for (int w = 0; w < ND; w++)
        for (int b = 0; b < 8; b++)
          dv[ND*8 - 1 - (w*8 + b) + 128] = stim[w][l + 16*b];
      for (int deg = ND*8 + 127; deg >= 128; deg--)
        if (dv[deg]) dv = dv ^ (g << (deg - 128));
      rem[l] = dv[127:0];
    end
    for (int w = 0; w < ND; w++) expw[w] = stim[w];
    for (int k = 0; k < NC - ND; k++) begin
      expw[ND + k] = '0;
      for (int l = 0; l < 16; l++)
        for (int b = 0; b < 8; b++)
          expw[ND + k][l + 16*b] = rem[l][127 - 8*k - b];
    end
  endtask

  // Hold one input word until an enabled edge has taken it.
  task automatic drive_word(input logic v, input logic s, input logic [127:0] d, input bit en_rand);
    do begin
      iclkena = en_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ival    = v;
      isop    = s;
      idat    = d;
      @(posedge iclk);
      @(negedge iclk);
    end while (!iclkena);
  endtask

  task automatic run_frame(input int n, input bit gaps, input bit en_rand, input bit lat_chk);
    int base;
    for (int w = 0; w < n; w++) begin
      if (gaps && $urandom_range(0, 3) == 0)
        drive_word(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, en_rand);
      base = cap_dat.size();
      drive_word(1'b1, (w == 0), stim[w], en_rand);
      if (lat_chk) begin
        #1;
        check($sformatf("latency_w%0d", w), 128'(cap_dat.size()), 128'(base + 1));
      end
    end
    drive_word(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic compare_frame(input string tag, input int base);
    int nsop;
    check({tag, "_count"}, 128'(cap_dat.size()), 128'(base + NC));
    if (cap_dat.size() >= base + NC) begin
      nsop = 0;
      for (int i = 0; i < NC; i++) begin
        check($sformatf("%s_w%0d", tag, i), cap_dat[base + i], expw[i]);
        nsop += int'(cap_sop[base + i]);
      end
      check({tag, "_sop_first"}, 128'(cap_sop[base]), 128'(1));
      check({tag, "_sop_count"}, 128'(nsop), 128'(1));
    end
  endtask

  task automatic clear_stim();
    for (int w = 0; w < NC; w++) stim[w] = '0;
  endtask

  task automatic rand_stim();
    for (int w = 0; w < NC; w++) stim[w] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    ireset  = 1'b1;
    iclkena = 1'b1;
    ival    = 1'b0;
    isop    = 1'b0;
    idat    = '0;

    // Reset state
    #2 ireset = 1'b0;
    #1;
    check("reset_oval", 128'(oval), 128'(0));
    check("reset_osop", 128'(osop), 128'(0));
    check("reset_odat", odat, '0);
    @(negedge iclk);
    @(negedge iclk);
    ireset = 1'b1;
    @(negedge iclk);

    // All-zero frame, 1-cycle latency per word
    clear_stim();
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b1);
    compare_frame("zero", 0);

    // Single x^0 bit in lane 0: remainder 0x87
    clear_stim();
    stim[238][112] = 1'b1;
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    compare_frame("lane0", 0);
    check("lane0_w238", cap_dat[238], 128'(1) << 112);
    check("lane0_w254", cap_dat[254], (128'(1) << 0) | (128'(1) << 80) | (128'(1) << 96) | (128'(1) << 112));
    check("lane0_w253", cap_dat[253], '0);

    // Same bit in lane 5
    clear_stim();
    stim[238][117] = 1'b1;
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    compare_frame("lane5", 0);
    check("lane5_w254", cap_dat[254], (128'(1) << 5) | (128'(1) << 85) | (128'(1) << 101) | (128'(1) << 117));

    // Random frame A (idat junk during parity words must be ignored)
    rand_stim();
    fr_a = stim;
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    compare_frame("rand_a", 0);
    for (int k = 0; k < 16; k++) par_a[k] = cap_dat[ND + k];

    // Random frame B
    rand_stim();
    fr_b = stim;
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    compare_frame("rand_b", 0);
    for (int k = 0; k < 16; k++) par_b[k] = cap_dat[ND + k];

    // A^B: model plus linearity
    for (int w = 0; w < NC; w++) stim[w] = fr_a[w] ^ fr_b[w];
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    compare_frame("rand_axb", 0);
    for (int k = 0; k < 16; k++)
      check($sformatf("linear_k%0d", k), cap_dat[ND + k], par_a[k] ^ par_b[k]);

    // Frame A again with ival gaps and random clock enable
    stim = fr_a;
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b1, 1'b1, 1'b0);
    compare_frame("gapped_a", 0);

    // isop at word 100 aborts frame 1; frame 2 must encode from scratch
    cap_dat.delete(); cap_sop.delete();
    for (int w = 0; w < 100; w++)
      drive_word(1'b1, (w == 0), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    rand_stim();
    model();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    check("abort_first_sop", 128'(cap_sop[0]), 128'(1));
    compare_frame("abort_f2", 100);

    // Reset mid-frame: outputs clear at once, next frame is clean
    for (int w = 0; w < 50; w++)
      drive_word(1'b1, (w == 0), {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    #2 ireset = 1'b0;
    #1;
    check("midrst_oval", 128'(oval), 128'(0));
    check("midrst_osop", 128'(osop), 128'(0));
    check("midrst_odat", odat, '0);
    @(negedge iclk);
    ival = 1'b0;
    isop = 1'b0;
    @(negedge iclk);
    ireset = 1'b1;
    @(negedge iclk);
    rand_stim();
    model();
    cap_dat.delete(); cap_sop.delete();
    run_frame(NC, 1'b0, 1'b0, 1'b0);
    compare_frame("post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/super_fec_i3_enc.md
Name: super_fec_i3_enc

Overview:
- Systematic frame encoder for the super-FEC (G.975.1 I.3-style) datapath. It sits ahead of the QPSK mapper and channel in the codec chain.
- One frame is 255 words of 128 bits: words 0..238 carry 30592 data bits, words 239..254 carry 2048 parity bits (rate 239/255).
- Parity comes from 16 interleaved lanes. Each lane runs a degree-128 polynomial LFSR that absorbs 8 bits per word.

Parameters:
- pPOLY, 128'h87, low 128 coefficients of the generator g(x); the x^128 term is implied. Default g(x) = x^128+x^7+x^2+x+1.
- pDATA_WORDS, 239, data words per frame.
- pCODE_WORDS, 255, total words per frame; parity words = pCODE_WORDS-pDATA_WORDS, fixed at 16 (16 lanes × 128 bits / 128).

Ports:
- iclk, input, 1, clock, rising edge.
- ireset, input, 1, reset, asynchronous, active-low.
- iclkena, input, 1, clock enable; all state holds when low.
- ival, input, 1, input word valid.
- isop, input, 1, start of frame, qualified by ival.
- idat, input, 128, input word; ignored during parity words (source drives 0).
- oval, output, 1, output word valid.
- osop, output, 1, output start of frame.
- odat, output, 128, output word: data copy or parity.

Behaviour:
- Reset (ireset=0, asynchronous): oval=0, osop=0, odat=0, word counter=0, all 16 lane registers=0.
- Clock enable: every register updates only when iclkena=1.
- Latency: exactly 1 cycle. oval/osop are ival/isop registered, and odat is registered at the same edge.
- Cycles with ival=0 leave the counter and LFSRs unchanged, give oval=0 next cycle, and hold odat.
- Word index w:
  - ival&isop gives w=0 and clears all lane registers before absorbing that word.
  - Otherwise w = previous+1 per valid word, wrapping 254→0.
  - Wrap to 0 without isop also clears the lanes (implicit new frame).
- Lane mapping: lane l (0..15) owns bits l+16*b, b=0..7. Within a word, bit b=0 is the first (highest-degree) bit fed.
- Data words (w<239):
  - odat = idat.
  - Each lane register r[127:0] absorbs its 8 bits serially in order b=0..7: fb = r[127]^bit; r = (r<<1) ^ (fb ? pPOLY : 0).
  - Implement as a combinational 8-step unroll in one cycle.
- Result after word 238: r = m(x)·x^128 mod g(x) per lane, where the lane message is bits in feed order with the first bit at the highest degree.
- Parity words (w=239..254, k=w-239):
  - odat bit l+16*b = lane l r[127-b]; then r <<= 8 with zero fill.
  - Word k therefore carries the original r[127-8k-b].
  - idat is ignored.
- isop arriving mid-frame aborts the current frame immediately: no parity is emitted for it, and the new frame starts at w=0.
- Reset mid-frame: all state clears; the next frame begins on isop.
- Output osop=1 exactly on the w=0 output word.

Test Plan:
- Reset, then an all-zero 255-word frame with isop on word 0 → 255 output words all zero; osop only on the first; each output exactly 1 cycle after its input.
- Single 1 at idat[112] of word 238 (lane 0, b=7, i.e. x^0), all else zero → words 0..237 and 239..253 zero, word 238 = bit112 only, word 254 = bits 0,80,96,112 set (0x87 remainder); all other lanes' parity zero.
- Same single bit moved to lane 5 (idat[117], word 238) → word 254 bits 5,85,101,117 set.
- Random frames A, B and A^B → parity(A^B) = parity(A)^parity(B) (linearity); data words echoed unchanged; compare against a bit-serial software LFSR model.
- iclkena toggled randomly mid-frame, and ival gaps inserted → output sequence identical to the uninterrupted run.
- isop at word 100 of frame 1 → counter restarts, new frame's parity matches a fresh encode. Separately, ireset asserted mid-frame → outputs 0 at once, clean next frame.
